alu_pipe: RTL
=============

Name: alu_pipe

Overview:
Parametrised registered ALU with a valid/ready handshake on both input and output sides. It executes single-cycle arithmetic and logic ops, plus an iterative shift-add multiply, and reports zero/carry/overflow/error flags. It sits between an operand source (sequencer or register file) and a result sink that may apply backpressure. It supersedes the fixed 16-bit select-driven ALU in the datapath.

Parameters:
- WIDTH, 16, operand/result width; power of two, at least 4.
- MUL_EN, 1, 1 = MUL opcode implemented; 0 = MUL treated as an illegal opcode.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands/opcode valid.
- in_ready  output  1  block can accept; transfer when in_valid && in_ready at a clk edge.
- op  input  4  opcode.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  result/flags valid.
- out_ready  input  1  sink accepts; transfer when out_valid && out_ready.
- result  output  WIDTH  registered result.
- flag_z  output  1  result == 0.
- flag_c  output  1  carry / no-borrow / multiply high-half nonzero.
- flag_v  output  1  signed overflow (ADD/SUB only).
- op_err  output  1  opcode was illegal.

Behaviour:
- Reset (async, active-low) forces: state IDLE, out_valid=0, result=0, all flags 0, op_err=0, counter 0. in_ready=1 after release. An in-flight MUL is discarded.
- Opcodes:
  - 0 ADD a+b
  - 1 SUB a-b, computed as a+~b+1
  - 2 NOTA ~a
  - 3 NOTB ~b
  - 4 GTU (a>b unsigned ? 1 : 0)
  - 5 AND
  - 6 OR
  - 7 XOR
  - 8 SHL a<<b[log2(WIDTH)-1:0]
  - 9 SHR logical, same shift amount
  - 10 MUL low WIDTH bits of a*b, unsigned
  - 11-15 illegal.
- Illegal opcode (including MUL when MUL_EN=0): executes ADD and sets op_err=1 alongside that result.
- Flags:
  - flag_c: ADD = carry-out of bit WIDTH-1; SUB = carry-out of a+~b+1 (1 when a>=b); MUL = 1 if product bits [2W-1:W] are nonzero; all other ops 0.
  - flag_v: ADD/SUB = signed overflow; all other ops 0.
  - flag_z: set for every op.
- States: IDLE, MUL_BUSY.
- in_ready = (state==IDLE) && (!out_valid || out_ready). It is 0 throughout MUL_BUSY.
- IDLE, single-cycle op accepted at edge e0: result, flags and out_valid=1 are registered at e0, so there is 1-cycle latency. Back-to-back accepts give throughput of 1 op per cycle while out_ready=1.
- IDLE, MUL accepted at e0:
  - Latch operands, clear the 2W accumulator, out_valid goes 0 (the previous result is consumed in the same cycle), go to MUL_BUSY.
  - One shift-add iteration per cycle for WIDTH iterations.
  - Result, flags and out_valid=1 appear at edge e(WIDTH); then return to IDLE.
- Output hold: while out_valid && !out_ready, result, flags and op_err are stable and in_ready=0.
- out_valid clears on an out_ready transfer unless a new op is accepted in the same cycle.
- Inputs are sampled only on an accept edge; changes to a/b/op outside an accept have no effect, including during MUL_BUSY.
- in_valid while in_ready=0: ignored. The source must hold its values.
- Reset mid-MUL or mid-hold: outputs clear immediately (asynchronous), no partial result is emitted.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams OP_ADD..OP_MUL, OP_W=4
  - state encoding IDLE/MUL_BUSY
  - a flags struct {z,c,v}
- Sub-module alu_mul_seq: WIDTH-iteration shift-add unsigned multiplier.
  - Inputs: start, a, b.
  - Outputs: done pulse and 2W-bit product.
  - Clock clk and reset reset_n (async active-low).
- The top level holds the combinational op decode, flag logic, handshake and output register.

Test Plan (WIDTH=16, MUL_EN=1):
- ADD a=0xFFFF b=0x0001 -> result 0x0000, z=1, c=1, v=0, op_err=0; out_valid 1 cycle after accept.
- SUB a=0x8000 b=0x0001 -> 0x7FFF, c=1, v=1; GTU a=0x0005 b=0xFFFF -> 0x0000, z=1.
- MUL 0x0123*0x0010 -> 0x1230, c=0, out_valid exactly 16 cycles after accept, in_ready=0 meanwhile. Then MUL 0x1000*0x0010 -> 0x0000, z=1, c=1.
- Backpressure: out_ready=0, ADD 3+4 then ADD 1+1 presented -> result holds 0x0007, in_ready=0, second op not taken. Raise out_ready -> second accepted, result 0x0002 next cycle.
- Reset asserted 5 cycles into a MUL, asynchronously mid-cycle -> out_valid/result/flags 0 immediately; after release in_ready=1 and no stale MUL result appears.
- op=0xF a=3 b=4 -> result 0x0007, op_err=1. Then SHL a=0x0001 b=0x0013 -> 0x0008 (shift amount 3), op_err=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: opcodes, control state encoding
// and the packed status-flag bundle.
package alu_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
    localparam logic [OP_W-1:0] OP_NOTA = 4'd2;
    localparam logic [OP_W-1:0] OP_NOTB = 4'd3;
    localparam logic [OP_W-1:0] OP_GTU  = 4'd4;
    localparam logic [OP_W-1:0] OP_AND  = 4'd5;
    localparam logic [OP_W-1:0] OP_OR   = 4'd6;
    localparam logic [OP_W-1:0] OP_XOR  = 4'd7;
    localparam logic [OP_W-1:0] OP_SHL  = 4'd8;
    localparam logic [OP_W-1:0] OP_SHR  = 4'd9;
    localparam logic [OP_W-1:0] OP_MUL  = 4'd10;

    typedef enum logic {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic z;
        logic c;
        logic v;
    } flags_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add unsigned multiplier: one partial-product add per clock,
// WIDTH iterations after start.
module alu_mul_seq #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int              CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_mplier;
    logic [CW-1:0]      r_cnt;
    logic               r_busy;
    logic [2*WIDTH-1:0] w_acc_next;

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

    // done and product look one iteration ahead so the caller can register
    // the final product on the same edge that performs the last iteration.
    assign done    = r_busy && (r_cnt == LAST);
    assign product = w_acc_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
        end else if (start) begin
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_acc    <= '0;
            r_mplier <= b;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready on both sides; single-cycle ops have one
// cycle of latency, MUL runs through the sequential multiplier.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v,
    output logic             op_err
);

    localparam int SW = $clog2(WIDTH);

    state_t             r_state;
    state_t             w_state_next;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_result;
    flags_t             r_flags;
    logic               r_op_err;

    logic               w_accept;
    logic               w_is_mul;
    logic               w_illegal;
    logic               w_mul_start;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_product;
    logic [WIDTH-1:0]   w_bop;
    logic               w_cin;
    logic [WIDTH:0]     w_sum;
    logic               w_ovf;
    logic [SW-1:0]      w_shamt;
    logic [WIDTH-1:0]   w_alu_result;
    flags_t             w_alu_flags;

    assign in_ready    = (r_state == IDLE) && (!r_out_valid || out_ready);
    assign w_accept    = in_valid && in_ready;
    assign w_is_mul    = MUL_EN && (op == OP_MUL);
    assign w_illegal   = (op > OP_MUL) || ((op == OP_MUL) && !MUL_EN);
    assign w_mul_start = w_accept && w_is_mul;
    assign w_shamt     = b[SW-1:0];

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign flag_z    = r_flags.z;
    assign flag_c    = r_flags.c;
    assign flag_v    = r_flags.v;
    assign op_err    = r_op_err;

    // SUB shares the adder as a + ~b + 1; illegal opcodes fall through to ADD.
    always_comb begin
        w_bop = b;
        w_cin = 1'b0;
        if (op == OP_SUB) begin
            w_bop = ~b;
            w_cin = 1'b1;
        end
    end

    assign w_sum = {1'b0, a} + {1'b0, w_bop} + {{WIDTH{1'b0}}, w_cin};
    assign w_ovf = (a[WIDTH-1] == w_bop[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);

    always_comb begin
        w_alu_result = w_sum[WIDTH-1:0];
        w_alu_flags  = '0;
        case (op)
            OP_ADD, OP_SUB: begin
                w_alu_flags.c = w_sum[WIDTH];
                w_alu_flags.v = w_ovf;
            end
            OP_NOTA: w_alu_result = ~a;
            OP_NOTB: w_alu_result = ~b;
            OP_GTU:  w_alu_result = {{(WIDTH-1){1'b0}}, (a > b)};
            OP_AND:  w_alu_result = a & b;
            OP_OR:   w_alu_result = a | b;
            OP_XOR:  w_alu_result = a ^ b;
            OP_SHL:  w_alu_result = a << w_shamt;
            OP_SHR:  w_alu_result = a >> w_shamt;
            default: begin
                w_alu_flags.c = w_sum[WIDTH];
                w_alu_flags.v = w_ovf;
            end
        endcase
        w_alu_flags.z = (w_alu_result == '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:     if (w_mul_start) w_state_next = MUL_BUSY;
            MUL_BUSY: if (w_mul_done)  w_state_next = IDLE;
            default:  w_state_next = IDLE;
        endcase
    end

    // A MUL accept drops out_valid at once; the old result was consumed
    // in the same cycle because in_ready required out_ready.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_flags     <= '0;
            r_op_err    <= 1'b0;
        end else if (r_state == MUL_BUSY) begin
            if (w_mul_done) begin
                r_out_valid <= 1'b1;
                r_result    <= w_product[WIDTH-1:0];
                r_flags.z   <= (w_product[WIDTH-1:0] == '0);
                r_flags.c   <= |w_product[2*WIDTH-1:WIDTH];
                r_flags.v   <= 1'b0;
                r_op_err    <= 1'b0;
            end
        end else if (w_accept) begin
            if (w_is_mul) begin
                r_out_valid <= 1'b0;
            end else begin
                r_out_valid <= 1'b1;
                r_result    <= w_alu_result;
                r_flags     <= w_alu_flags;
                r_op_err    <= w_illegal;
            end
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    alu_mul_seq #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (w_mul_start),
        .a      (a),
        .b      (b),
        .done   (w_mul_done),
        .product(w_product)
    );

endmodule
